pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer for the soft RISC-V core, generalising the single-width PC register. It sits in the fetch/execute boundary, advances once per execute phase under a 3-bit command, and covers sequential, relative, absolute, trap-entry and trap-return flows. It also detects misaligned targets and captures exception PC and faulting address, with an optional return-address stack.

## Interface
- XLEN, 32: address width in bits.
- RESET_VECTOR, `PROGRAM_BASE_ADDR: PC value after reset.
- TRAP_VECTOR, 32'h0000_0100: trap entry address (must be 4-aligned).
- RAS_DEPTH, 4: return-address-stack entries, power of two ≥2 (used only with PC_RAS_EN).

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rstn  in  1  reset; one clock, synchronous, active-low.
- advance  in  1  execute-phase strobe; PC and state update only when high.
- cmd  in  3  0 SEQ, 1 REL, 2 ABS, 3 TRAP, 4 MRET, 5 CALL_REL, 6 CALL_ABS, 7 RET.
- operand  in  XLEN  offset (REL/CALL_REL) or target (ABS/CALL_ABS/RET).
- pc  out  XLEN  current PC.
- epc  out  XLEN  PC saved at last trap entry.
- tval  out  XLEN  faulting target of last misalignment trap, else 0 on TRAP.
- misaligned  out  1  one-cycle pulse: last advance trapped on a misaligned target.
- ras_empty  out  1  RAS holds no entries (constant 1 without PC_RAS_EN).

## Operation
- Target computation at advance=1:
  - SEQ: pc+4.
  - REL/CALL_REL: pc+operand.
  - ABS/CALL_ABS: operand with bit0 cleared.
  - TRAP: TRAP_VECTOR.
  - MRET: epc.
  - RET: described under Configuration.
- All arithmetic is modulo 2^XLEN. Wrap-around is silent: pc=FFFF_FFFC with SEQ gives 0.
- Alignment check applies to REL, ABS, CALL_*, RET. If target[1:0]≠0:
  - pc←TRAP_VECTOR, epc←pc, tval←target, misaligned←1.
  - No RAS push or pop occurs.
- TRAP: pc←TRAP_VECTOR, epc←pc, tval←0.
- MRET: pc←epc. No alignment fault is possible, because epc is always 4-aligned.
- advance=0: all registers hold, and misaligned clears to 0.
- Reset values: pc=RESET_VECTOR, epc=0, tval=0, misaligned=0, RAS count=0, ras_empty=1.
- Reset dominates: rstn low at a clock edge discards any concurrent advance/cmd.

## Timing
- Single-cycle latency: advance and cmd sampled at edge N, new pc visible after edge N.
- misaligned is registered. It is high exactly in the cycle where pc first shows TRAP_VECTOR from a fault.
- Back-to-back advances are legal every cycle, with no bubbles.
- epc and tval update on the same edge as pc.
- RAS push and pop complete on the same edge. ras_empty reflects the post-update count.

## Configuration
- PC_RAS_EN defined:
  - CALL_REL/CALL_ABS with an aligned target push pc+4 onto the RAS.
  - If the RAS is full, the oldest entry is overwritten (circular pointer wraps) and the count saturates at RAS_DEPTH.
  - RET with a non-empty RAS pops the top entry and uses it as the target; operand is ignored.
  - RET with an empty RAS uses operand (bit0 cleared).
  - A popped target that is misaligned traps as usual. On that fault the entry is not consumed.
  - The RAS is cleared on reset only. TRAP and MRET leave it untouched.
- PC_RAS_EN undefined:
  - No stack storage is instantiated and ras_empty is tied to 1.
  - CALL_REL≡REL, CALL_ABS≡ABS, RET≡ABS.

## Test plan
- Reset and SEQ: hold rstn=0 for 2 cycles, release, then advance SEQ ×3 → pc = RESET_VECTOR, +4, +8, +C. Then rstn=0 together with advance → pc=RESET_VECTOR next cycle.
- Branch and wrap: pc=0x100, REL operand=0xFFFF_FFF8 → pc=0xF8. pc=0xFFFF_FFFC, SEQ → pc=0.
- Misalignment: pc=0x200, ABS operand=0x303 → pc=0x100, epc=0x200, tval=0x302, misaligned=1 for one cycle. Then MRET → pc=0x200.
- Hold: advance=0 for 5 cycles with cmd=REL, operand=0x40 → pc unchanged, misaligned=0.
- RAS (PC_RAS_EN, depth 4):
  - CALL_ABS ×5 from pc=0x1000,0x2000,0x3000,0x4000,0x5000 to targets 0x2000,…,0x6000.
  - Then RET ×5 with operand=0x8000 → pc = 0x5004, 0x4004, 0x3004, 0x2004, then 0x8000 (oldest entry overwritten). ras_empty=1 after the fourth RET.
- RAS disabled: the same sequence → each RET goes to 0x8000, and ras_empty stays 1.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the fetch/execute boundary.
// Covers sequential, relative, absolute, trap-entry and trap-return flows.
// It detects misaligned targets and captures the exception PC and faulting address.
// Optional return-address stack: define PC_RAS_EN.
`ifndef PROGRAM_BASE_ADDR
`define PROGRAM_BASE_ADDR 32'h0000_0000
`endif

module pc_sequencer #(
  parameter int unsigned XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(`PROGRAM_BASE_ADDR),
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(32'h0000_0100),
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            advance,
  input  logic [2:0]      cmd,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] tval,
  output logic            misaligned,
  output logic            ras_empty
);

  typedef enum logic [2:0] {
    CMD_SEQ      = 3'd0,
    CMD_REL      = 3'd1,
    CMD_ABS      = 3'd2,
    CMD_TRAP     = 3'd3,
    CMD_MRET     = 3'd4,
    CMD_CALL_REL = 3'd5,
    CMD_CALL_ABS = 3'd6,
    CMD_RET      = 3'd7
  } cmd_e;

  // Elaboration-time sanity checks on the configuration.
  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras_depth
    $error("pc_sequencer: RAS_DEPTH must be a power of two >= 2");
  end
  if (TRAP_VECTOR[1:0] != 2'b00) begin : g_bad_trap_vector
    $error("pc_sequencer: TRAP_VECTOR must be 4-aligned");
  end

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic            misaligned_q, misaligned_d;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] operand_even;
  logic            check_align;

  assign operand_even = {operand[XLEN-1:1], 1'b0};

`ifdef PC_RAS_EN
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  ras_q [RAS_DEPTH];
  logic [XLEN-1:0]  ras_d [RAS_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ras_empty_q, ras_empty_d;
  logic             ras_hit;
  logic [XLEN-1:0]  ras_top;
  logic             do_push, do_pop;

  assign ras_hit = (cnt_q != '0);
  assign ras_top = ras_q[wr_ptr_q - PTR_W'(1)];
`endif

  // Next-state: target select, alignment trap and RAS push/pop decisions.
  always_comb begin
    pc_d         = pc_q;
    epc_d        = epc_q;
    tval_d       = tval_q;
    misaligned_d = 1'b0;
    target       = pc_q + XLEN'(4);
    check_align  = 1'b0;
`ifdef PC_RAS_EN
    do_push      = 1'b0;
    do_pop       = 1'b0;
`endif

    case (cmd_e'(cmd))
      CMD_SEQ:                  target = pc_q + XLEN'(4);
      CMD_REL, CMD_CALL_REL: begin
        target      = pc_q + operand;
        check_align = 1'b1;
      end
      CMD_ABS, CMD_CALL_ABS: begin
        target      = operand_even;
        check_align = 1'b1;
      end
      CMD_TRAP:                 target = TRAP_VECTOR;
      CMD_MRET:                 target = epc_q;
      CMD_RET: begin
`ifdef PC_RAS_EN
        target      = ras_hit ? ras_top : operand_even;
`else
        target      = operand_even;
`endif
        check_align = 1'b1;
      end
      default:                  target = pc_q + XLEN'(4);
    endcase

    if (advance) begin
      if (cmd_e'(cmd) == CMD_TRAP) begin
        pc_d   = TRAP_VECTOR;
        epc_d  = pc_q;
        tval_d = '0;
      end else if (check_align && (target[1:0] != 2'b00)) begin
        // Misaligned target: enter the trap vector, stack left untouched.
        pc_d         = TRAP_VECTOR;
        epc_d        = pc_q;
        tval_d       = target;
        misaligned_d = 1'b1;
      end else begin
        pc_d = target;
`ifdef PC_RAS_EN
        do_push = (cmd_e'(cmd) == CMD_CALL_REL) || (cmd_e'(cmd) == CMD_CALL_ABS);
        do_pop  = (cmd_e'(cmd) == CMD_RET) && ras_hit;
`endif
      end
    end
  end

`ifdef PC_RAS_EN
  // RAS next-state: circular buffer, oldest entry overwritten when full.
  always_comb begin
    ras_d    = ras_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      ras_d[wr_ptr_q] = pc_q + XLEN'(4);
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
    end else if (do_pop) begin
      wr_ptr_d = wr_ptr_q - PTR_W'(1);
      cnt_d    = cnt_q - CNT_W'(1);
    end
    ras_empty_d = (cnt_d == '0);
  end

  // RAS storage and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      ras_empty_q <= 1'b1;
    end else begin
      ras_q       <= ras_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      ras_empty_q <= ras_empty_d;
    end
  end

  assign ras_empty = ras_empty_q;
`else
  assign ras_empty = 1'b1;
`endif

  // PC, exception-capture and fault-pulse registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q         <= RESET_VECTOR;
      epc_q        <= '0;
      tval_q       <= '0;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      tval_q       <= tval_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign pc         = pc_q;
  assign epc        = epc_q;
  assign tval       = tval_q;
  assign misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; expectations follow PC_RAS_EN if defined.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0040;
  localparam logic [31:0] TV = 32'h0000_0100;

  localparam logic [2:0] SEQ = 3'd0, REL = 3'd1, ABS = 3'd2, TRAP = 3'd3,
                         MRET = 3'd4, CALL_ABS = 3'd6, RET = 3'd7;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        advance = 1'b0;
  logic [2:0]  cmd = 3'd0;
  logic [31:0] operand = '0;
  logic [31:0] pc, epc, tval;
  logic        misaligned, ras_empty;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] ret_exp   [5];
  logic        empty_exp [5];
  logic        empty_after_calls;

  pc_sequencer #(
    .XLEN(32),
    .RESET_VECTOR(RV),
    .TRAP_VECTOR(TV),
    .RAS_DEPTH(4)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .advance(advance),
    .cmd(cmd),
    .operand(operand),
    .pc(pc),
    .epc(epc),
    .tval(tval),
    .misaligned(misaligned),
    .ras_empty(ras_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; return 1 time unit after the rising edge.
  task automatic step(input logic r, input logic a, input logic [2:0] c, input logic [31:0] op);
    @(negedge clk);
    rstn    = r;
    advance = a;
    cmd     = c;
    operand = op;
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef PC_RAS_EN
    ret_exp   = '{32'h5004, 32'h4004, 32'h3004, 32'h2004, 32'h8000};
    empty_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    empty_after_calls = 1'b0;
`else
    ret_exp   = '{32'h8000, 32'h8000, 32'h8000, 32'h8000, 32'h8000};
    empty_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    empty_after_calls = 1'b1;
`endif

    // Reset for two cycles.
    step(1'b0, 1'b0, SEQ, '0);
    step(1'b0, 1'b0, SEQ, '0);
    check("rst_pc", pc, RV);
    check("rst_epc", epc, 32'h0);
    check("rst_tval", tval, 32'h0);
    check("rst_mis", 32'(misaligned), 32'h0);
    check("rst_ras_empty", 32'(ras_empty), 32'h1);

    step(1'b1, 1'b0, SEQ, '0);
    check("rel_idle_pc", pc, RV);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b1, SEQ, '0);
      check("seq_pc", pc, RV + 32'(4 * i));
    end

    // Reset dominates a concurrent advance.
    step(1'b0, 1'b1, ABS, 32'h0000_0800);
    check("rst_dom_pc", pc, RV);

    // Relative branch with negative offset and silent wrap.
    step(1'b1, 1'b1, ABS, 32'h0000_0100);
    check("abs_pc", pc, 32'h0000_0100);
    step(1'b1, 1'b1, REL, 32'hFFFF_FFF8);
    check("rel_neg_pc", pc, 32'h0000_00F8);
    step(1'b1, 1'b1, ABS, 32'hFFFF_FFFC);
    check("abs_top_pc", pc, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, SEQ, '0);
    check("wrap_pc", pc, 32'h0);

    // Misaligned absolute jump, bit0 dropped from tval.
    step(1'b1, 1'b1, ABS, 32'h0000_0200);
    step(1'b1, 1'b1, ABS, 32'h0000_0303);
    check("mis_pc", pc, TV);
    check("mis_epc", epc, 32'h0000_0200);
    check("mis_tval", tval, 32'h0000_0302);
    check("mis_flag", 32'(misaligned), 32'h1);
    step(1'b1, 1'b1, MRET, '0);
    check("mret_pc", pc, 32'h0000_0200);
    check("mret_mis", 32'(misaligned), 32'h0);

    // Hold: advance low with a live command present.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, REL, 32'h0000_0040);
      check("hold_pc", pc, 32'h0000_0200);
      check("hold_mis", 32'(misaligned), 32'h0);
    end

    // Misaligned relative branch; pulse lasts one cycle.
    step(1'b1, 1'b1, REL, 32'h0000_0002);
    check("mrel_pc", pc, TV);
    check("mrel_tval", tval, 32'h0000_0202);
    check("mrel_mis", 32'(misaligned), 32'h1);
    step(1'b1, 1'b0, SEQ, '0);
    check("mrel_pulse_end", 32'(misaligned), 32'h0);
    check("mrel_hold_epc", epc, 32'h0000_0200);

    // Explicit trap clears tval and saves pc.
    step(1'b1, 1'b1, SEQ, '0);
    check("pre_trap_pc", pc, 32'h0000_0104);
    step(1'b1, 1'b1, TRAP, 32'h0000_0008);
    check("trap_pc", pc, TV);
    check("trap_epc", epc, 32'h0000_0104);
    check("trap_tval", tval, 32'h0);
    check("trap_mis", 32'(misaligned), 32'h0);
    step(1'b1, 1'b1, MRET, '0);
    check("trap_mret_pc", pc, 32'h0000_0104);

    // Calls from 0x1000..0x5000, then five returns.
    step(1'b1, 1'b1, ABS, 32'h0000_1000);
    for (int i = 2; i <= 6; i++) begin
      step(1'b1, 1'b1, CALL_ABS, 32'(i * 32'h1000));
      check("call_pc", pc, 32'(i * 32'h1000));
    end
    check("call_ras_empty", 32'(ras_empty), 32'(empty_after_calls));
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, RET, 32'h0000_8000);
      check("ret_pc", pc, ret_exp[i]);
      check("ret_ras_empty", 32'(ras_empty), 32'(empty_exp[i]));
    end

    step(1'b1, 1'b0, SEQ, '0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
